// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampling UART receiver with one-byte holding register
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   baud_tick    one-clk pulse at 16x the bit rate
//   rx_in        asynchronous serial input, idle high
//   rx_data      received byte (LSB first on the line)
//   rx_valid     rx_data holds an unread byte
//   rx_ready     consumer accepts the byte when rx_valid && rx_ready
//   rx_busy      receiver FSM is not idle
//   frame_err    one-clk pulse: stop bit sampled low
//   parity_err   one-clk pulse: parity mismatch
//   overrun_err  one-clk pulse: good frame dropped, holding register full
module uart_rx_core #(
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baud_tick,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   localparam logic ODD_BIT = (PARITY_ODD != 0);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   state_t     state_q, state_d;
   logic [3:0] tcnt_q, tcnt_d;
   logic [2:0] bidx_q, bidx_d;
   logic [7:0] shift_q, shift_d;
   logic       par_bad_q, par_bad_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       frame_err_q, frame_err_d;
   logic       parity_err_q, parity_err_d;
   logic       overrun_err_q, overrun_err_d;

   logic       rxs;
   logic       stop_good;
   logic       stop_frame_bad;
   logic       stop_parity_bad;

   assign rxs = sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         state_q       <= S_IDLE;
         tcnt_q        <= 4'd0;
         bidx_q        <= 3'd0;
         shift_q       <= 8'h00;
         par_bad_q     <= 1'b0;
         rx_data_q     <= 8'h00;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         parity_err_q  <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         state_q       <= state_d;
         tcnt_q        <= tcnt_d;
         bidx_q        <= bidx_d;
         shift_q       <= shift_d;
         par_bad_q     <= par_bad_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_err_q   <= frame_err_d;
         parity_err_q  <= parity_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

   // Two-flop synchronizer for the asynchronous line.
   always_comb begin
      sync1_d = rx_in;
      sync2_d = sync1_q;
   end

   // Receive FSM: all counters advance only on baud_tick.
   always_comb begin
      state_d         = state_q;
      tcnt_d          = tcnt_q;
      bidx_d          = bidx_q;
      shift_d         = shift_q;
      par_bad_d       = par_bad_q;
      stop_good       = 1'b0;
      stop_frame_bad  = 1'b0;
      stop_parity_bad = 1'b0;

      if (baud_tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rxs) begin
                  state_d   = S_START;
                  tcnt_d    = 4'd0;
                  par_bad_d = 1'b0;
               end
            end
            S_START: begin
               // Mid-bit re-check of the start bit rejects short glitches.
               if (tcnt_q == 4'd7) begin
                  tcnt_d = 4'd0;
                  if (rxs) begin
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_DATA;
                     bidx_d  = 3'd0;
                  end
               end else begin
                  tcnt_d = tcnt_q + 4'd1;
               end
            end
            S_DATA: begin
               if (tcnt_q == 4'd15) begin
                  tcnt_d          = 4'd0;
                  shift_d[bidx_q] = rxs;
                  if (bidx_q == 3'd7) begin
                     bidx_d  = 3'd0;
                     state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bidx_d = bidx_q + 3'd1;
                  end
               end else begin
                  tcnt_d = tcnt_q + 4'd1;
               end
            end
            S_PARITY: begin
               if (tcnt_q == 4'd15) begin
                  tcnt_d    = 4'd0;
                  par_bad_d = (rxs != ((^shift_q) ^ ODD_BIT));
                  state_d   = S_STOP;
               end else begin
                  tcnt_d = tcnt_q + 4'd1;
               end
            end
            S_STOP: begin
               if (tcnt_q == 4'd15) begin
                  tcnt_d = 4'd0;
                  if (!rxs) begin
                     stop_frame_bad = 1'b1;
                     state_d        = S_WAIT_HIGH;
                  end else begin
                     state_d = S_IDLE;
                     if (par_bad_q) stop_parity_bad = 1'b1;
                     else           stop_good       = 1'b1;
                  end
               end else begin
                  tcnt_d = tcnt_q + 4'd1;
               end
            end
            S_WAIT_HIGH: begin
               // A held-low break must not be mistaken for a new start bit.
               if (rxs) state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               tcnt_d  = 4'd0;
            end
         endcase
      end
   end

   // Holding register and error pulses, all registered so rx_valid never
   // follows rx_ready combinationally.
   always_comb begin
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      frame_err_d   = stop_frame_bad;
      parity_err_d  = stop_parity_bad;
      overrun_err_d = 1'b0;

      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

      if (stop_good) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_err_d = 1'b1;
         end
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign rx_busy     = (state_q != S_IDLE);
   assign frame_err   = frame_err_q;
   assign parity_err  = parity_err_q;
   assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed scoreboard bench for uart_rx_core
module tb_uart_rx_core;

   localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clocks

   localparam logic [2:0] EV_LOAD = 3'd1;
   localparam logic [2:0] EV_FERR = 3'd2;
   localparam logic [2:0] EV_PERR = 3'd3;
   localparam logic [2:0] EV_OERR = 3'd4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       baud_tick = 1'b0;
   logic       rx_a = 1'b1, rx_b = 1'b1;
   logic       ready_a = 1'b1, ready_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b, busy_a, busy_b;
   logic       ferr_a, ferr_b, perr_a, perr_b, oerr_a, oerr_b;

   int n_tests = 0;
   int n_fail  = 0;
   int div     = 0;
   logic [11:0] sb[$];
   logic pv_a = 1'b0, pv_b = 1'b0;

   uart_rx_core #(.PARITY_EN(0), .PARITY_ODD(0)) u_dut_a (
      .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_a),
      .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a), .rx_busy(busy_a),
      .frame_err(ferr_a), .parity_err(perr_a), .overrun_err(oerr_a)
   );

   uart_rx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
      .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx_in(rx_b),
      .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b), .rx_busy(busy_b),
      .frame_err(ferr_b), .parity_err(perr_b), .overrun_err(oerr_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      baud_tick = (div == 3);
      div = (div + 1) % 4;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_match(input logic [11:0] obs);
      logic [11:0] exp;
      n_tests++;
      if (sb.size() == 0) exp = 12'hFFF;
      else                exp = sb.pop_front();
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL sb_event observed=%h expected=%h", obs, exp);
      end
   endtask

   // Observed events: valid rising edges (with data) and every error pulse cycle.
   always @(negedge clk) begin
      if (valid_a && !pv_a) sb_match({1'b0, EV_LOAD, data_a});
      if (ferr_a) sb_match({1'b0, EV_FERR, 8'h00});
      if (perr_a) sb_match({1'b0, EV_PERR, 8'h00});
      if (oerr_a) sb_match({1'b0, EV_OERR, 8'h00});
      if (valid_b && !pv_b) sb_match({1'b1, EV_LOAD, data_b});
      if (ferr_b) sb_match({1'b1, EV_FERR, 8'h00});
      if (perr_b) sb_match({1'b1, EV_PERR, 8'h00});
      if (oerr_b) sb_match({1'b1, EV_OERR, 8'h00});
      pv_a = valid_a;
      pv_b = valid_b;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setline(input bit u, input logic v);
      if (u) rx_b = v;
      else   rx_a = v;
   endtask

   task automatic expect_ev(input bit u, input logic [2:0] k, input logic [7:0] d);
      sb.push_back({u, k, d});
   endtask

   task automatic send_frame(input bit u, input logic [7:0] d, input bit par,
                             input logic pbit, input logic sbit);
      logic [7:0] b;
      b = d;
      setline(u, 1'b0);
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         setline(u, b[i]);
         wait_clks(BIT_CLKS);
      end
      if (par) begin
         setline(u, pbit);
         wait_clks(BIT_CLKS);
      end
      setline(u, sbit);
      wait_clks(BIT_CLKS);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data"},  {24'h0, data_a}, 32'h00);
      chk({tag, "_valid"}, {31'h0, valid_a}, 32'h0);
      chk({tag, "_busy"},  {31'h0, busy_a}, 32'h0);
      chk({tag, "_errs"},  {29'h0, ferr_a, perr_a, oerr_a}, 32'h0);
   endtask

   initial begin
      wait_clks(6);
      chk_reset_outputs("reset_a");
      chk("reset_b_valid", {31'h0, valid_b}, 32'h0);
      chk("reset_b_busy",  {31'h0, busy_b}, 32'h0);
      reset = 1'b0;
      wait_clks(20);

      // 0xA5, ready high: one load, valid clears after the handshake.
      expect_ev(1'b0, EV_LOAD, 8'hA5);
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      wait_clks(32);
      chk("a5_sb_empty", sb.size(), 32'd0);
      chk("a5_valid_cleared", {31'h0, valid_a}, 32'h0);
      chk("a5_data_kept", {24'h0, data_a}, 32'hA5);

      // Short low glitch: false start, no events.
      setline(1'b0, 1'b0);
      wait_clks(12);
      chk("glitch_busy", {31'h0, busy_a}, 32'h1);
      wait_clks(4);
      setline(1'b0, 1'b1);
      wait_clks(BIT_CLKS);
      chk("glitch_idle", {31'h0, busy_a}, 32'h0);
      chk("glitch_valid", {31'h0, valid_a}, 32'h0);

      // 0x3C with a low stop bit, then a 40-tick break.
      expect_ev(1'b0, EV_FERR, 8'h00);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      wait_clks(160);
      chk("break_sb_empty", sb.size(), 32'd0);
      chk("break_wait_high", {31'h0, busy_a}, 32'h1);
      chk("break_valid", {31'h0, valid_a}, 32'h0);
      setline(1'b0, 1'b1);
      wait_clks(32);
      chk("break_released", {31'h0, busy_a}, 32'h0);

      // Even parity on unit B: 0x07 has three ones, so the parity bit must be 1.
      expect_ev(1'b1, EV_PERR, 8'h00);
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      wait_clks(32);
      chk("par_bad_sb_empty", sb.size(), 32'd0);
      chk("par_bad_valid", {31'h0, valid_b}, 32'h0);
      expect_ev(1'b1, EV_LOAD, 8'h07);
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      wait_clks(32);
      chk("par_good_sb_empty", sb.size(), 32'd0);
      chk("par_good_data", {24'h0, data_b}, 32'h07);

      // Overrun: consumer stalled, second frame dropped.
      ready_a = 1'b0;
      expect_ev(1'b0, EV_LOAD, 8'h11);
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      wait_clks(32);
      expect_ev(1'b0, EV_OERR, 8'h00);
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      wait_clks(32);
      chk("ovr_sb_empty", sb.size(), 32'd0);
      chk("ovr_data_kept", {24'h0, data_a}, 32'h11);
      chk("ovr_valid_held", {31'h0, valid_a}, 32'h1);
      ready_a = 1'b1;
      wait_clks(1);
      ready_a = 1'b0;
      wait_clks(1);
      chk("ovr_valid_cleared", {31'h0, valid_a}, 32'h0);
      chk("ovr_data_after_read", {24'h0, data_a}, 32'h11);
      ready_a = 1'b1;

      // Reset in the middle of bit 4 of 0xFF.
      setline(1'b0, 1'b0);
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         setline(1'b0, 1'b1);
         wait_clks(BIT_CLKS);
      end
      wait_clks(BIT_CLKS / 2);
      chk("midrst_busy_before", {31'h0, busy_a}, 32'h1);
      reset = 1'b1;
      wait_clks(3);
      chk_reset_outputs("midrst");
      reset = 1'b0;
      wait_clks(400);
      chk("midrst_idle_after", {31'h0, busy_a}, 32'h0);
      chk("midrst_sb_empty", sb.size(), 32'd0);
      expect_ev(1'b0, EV_LOAD, 8'h5A);
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      wait_clks(32);
      chk("post_rst_data", {24'h0, data_a}, 32'h5A);
      chk("sb_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
